// File: rtl/lsu_controller_pkg.sv
// -----------------------------------------------------------------------------
// loopyV_data_types
// Shared types and helpers for the MEM-stage load/store unit.
//   LsuStateType : access sequencer states
//   LS_*         : funct3 encodings of the RV32 load/store size field
//   ls_legal     : funct3 names a supported load/store size
//   ls_aligned   : address is naturally aligned for the access size
//   ls_byte_en   : byte-enable pattern for a size and byte offset
// -----------------------------------------------------------------------------
package loopyV_data_types;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_WAIT_GNT,
        LSU_WAIT_RVALID
    } LsuStateType;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    function automatic logic ls_legal(input logic [2:0] funct3);
        logic ok;
        case (funct3)
            LS_B, LS_H, LS_W, LS_BU, LS_HU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // funct3[1:0] is the size for every legal encoding (00 byte, 01 half, 10 word)
    function automatic logic ls_aligned(input logic [2:0] funct3, input logic [1:0] offs);
        logic ok;
        case (funct3[1:0])
            2'b01:   ok = (offs[0] == 1'b0);
            2'b10:   ok = (offs == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] ls_byte_en(input logic [2:0] funct3, input logic [1:0] offs);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << offs;
            2'b01:   be = 4'b0011 << offs;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_controller_if.sv
// -----------------------------------------------------------------------------
// lsu_controller_if
// Request/grant/response data-memory port.
//   dmReq/dmGnt           : request handshake (LSU -> memory / memory -> LSU)
//   dmAddr/dmWe/dmBe/dmWData : access attributes, word-aligned address
//   dmRValid/dmRData/dmErr : response, dmErr qualified by dmRValid
// Modports: master (LSU side), slave (memory side).
// -----------------------------------------------------------------------------
interface lsu_controller_if;
    logic        dmReq;
    logic        dmGnt;
    logic [31:0] dmAddr;
    logic        dmWe;
    logic [3:0]  dmBe;
    logic [31:0] dmWData;
    logic        dmRValid;
    logic [31:0] dmRData;
    logic        dmErr;

    modport master (
        output dmReq, dmAddr, dmWe, dmBe, dmWData,
        input  dmGnt, dmRValid, dmRData, dmErr
    );

    modport slave (
        input  dmReq, dmAddr, dmWe, dmBe, dmWData,
        output dmGnt, dmRValid, dmRData, dmErr
    );
endinterface

// File: rtl/lsu_controller_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load extraction: picks the byte/halfword addressed by the low
// address bits out of the bus word and sign- or zero-extends it.
//   i_rdata  : raw bus read word
//   i_addr   : byte offset within the word
//   i_funct3 : load size/sign selector
//   o_data   : extended load result
// -----------------------------------------------------------------------------
module lsu_load_align
    import loopyV_data_types::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
    assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            LS_B:    o_data = {{24{w_byte[7]}}, w_byte};
            LS_BU:   o_data = {24'h0, w_byte};
            LS_H:    o_data = {{16{w_half[15]}}, w_half};
            LS_HU:   o_data = {16'h0, w_half};
            default: o_data = i_rdata;
        endcase
    end
endmodule

// File: rtl/lsu_controller.sv
// -----------------------------------------------------------------------------
// lsu_controller
// MEM-stage load/store sequencer: issues one data-memory access at a time,
// stalls the pipeline until the response, forms byte enables / store lanes and
// returns the extended load word one cycle after the response (WB alignment).
// Optional feature macro: LSU_TIMEOUT_EN (bus wait limit of TIMEOUT_CYCLES).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   memReqMEM/memWeMEM       : access present / store select
//   dmAddrMEM/storeDataMEM   : byte address / rs2
//   loadStoreByteSelectMEM   : funct3
//   stallMEM                 : pipeline freeze
//   loadDataWB/loadValidWB   : load result and its one-cycle valid
//   misalignedFault          : misaligned access pulse (same cycle)
//   accessError              : illegal funct3 (same cycle) or bus error/timeout
//                              (cycle after)
//   dm                       : data-memory port (master side)
// -----------------------------------------------------------------------------
module lsu_controller
    import loopyV_data_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memReqMEM,
    input  logic        memWeMEM,
    input  logic [31:0] dmAddrMEM,
    input  logic [31:0] storeDataMEM,
    input  logic [2:0]  loadStoreByteSelectMEM,
    output logic        stallMEM,
    output logic [31:0] loadDataWB,
    output logic        loadValidWB,
    output logic        misalignedFault,
    output logic        accessError,
    lsu_controller_if.master dm
);
    LsuStateType r_state, w_state_next;

    logic        w_legal, w_aligned, w_access, w_accept, w_rsp, w_timeout;
    logic [3:0]  w_be_in;
    logic [31:0] w_wdata_in;
    logic [31:0] w_load_ext;

    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [31:0] r_load_data;
    logic        r_load_valid;
    logic        r_rsp_err;

    assign w_legal   = ls_legal(loadStoreByteSelectMEM);
    assign w_aligned = ls_aligned(loadStoreByteSelectMEM, dmAddrMEM[1:0]);
    assign w_access  = memReqMEM & w_legal & w_aligned;
    assign w_accept  = !rst && (r_state == LSU_IDLE) && w_access;
    assign w_rsp     = (r_state == LSU_WAIT_RVALID) && dm.dmRValid;
    assign w_be_in   = ls_byte_en(loadStoreByteSelectMEM, dmAddrMEM[1:0]);

    // Store lane replication: byte -> all lanes, half -> both halves, word as-is
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_wdata_in[gi*8 +: 8] =
                (loadStoreByteSelectMEM[1:0] == 2'b00) ? storeDataMEM[7:0] :
                (loadStoreByteSelectMEM[1:0] == 2'b01) ? storeDataMEM[(gi%2)*8 +: 8] :
                                                         storeDataMEM[gi*8 +: 8];
        end
    endgenerate

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    // Restart on every entry into a wait state; a real grant/response wins
    always_ff @(posedge clk) begin
        if (rst || r_state == LSU_IDLE || w_state_next != r_state)
            r_wait_cnt <= '0;
        else
            r_wait_cnt <= r_wait_cnt + 1'b1;
    end

    assign w_timeout = (r_state != LSU_IDLE)
                    && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1))
                    && !((r_state == LSU_WAIT_GNT) && dm.dmGnt)
                    && !w_rsp;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= LSU_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        dm.dmReq     = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                if (w_accept) begin
                    dm.dmReq     = 1'b1;
                    w_state_next = dm.dmGnt ? LSU_WAIT_RVALID : LSU_WAIT_GNT;
                end
            end
            LSU_WAIT_GNT: begin
                dm.dmReq = 1'b1;
                if (dm.dmGnt) begin
                    w_state_next = LSU_WAIT_RVALID;
                end else if (w_timeout) begin
                    dm.dmReq     = 1'b0;
                    w_state_next = LSU_IDLE;
                end
            end
            LSU_WAIT_RVALID: begin
                if (dm.dmRValid || w_timeout) w_state_next = LSU_IDLE;
            end
            default: w_state_next = LSU_IDLE;
        endcase
        if (rst) dm.dmReq = 1'b0;
    end

    // Accepting cycle drives the bus straight from MEM; afterwards the latch holds it
    assign dm.dmAddr  = w_accept ? {dmAddrMEM[31:2], 2'b00} : {r_addr[31:2], 2'b00};
    assign dm.dmWe    = w_accept ? memWeMEM     : r_we;
    assign dm.dmBe    = w_accept ? w_be_in      : r_be;
    assign dm.dmWData = w_accept ? w_wdata_in   : r_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_funct3 <= '0;
        end else if (w_accept) begin
            r_addr   <= dmAddrMEM;
            r_we     <= memWeMEM;
            r_be     <= w_be_in;
            r_wdata  <= w_wdata_in;
            r_funct3 <= loadStoreByteSelectMEM;
        end
    end

    lsu_load_align u_load_align (
        .i_rdata  (dm.dmRData),
        .i_addr   (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_load_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_rsp_err    <= 1'b0;
            if (w_rsp) begin
                r_rsp_err <= dm.dmErr;
                if (!r_we) begin
                    r_load_valid <= 1'b1;
                    r_load_data  <= dm.dmErr ? 32'h0 : w_load_ext;
                end
            end else if (w_timeout) begin
                r_rsp_err <= 1'b1;
                if (!r_we) begin
                    r_load_valid <= 1'b1;
                    r_load_data  <= 32'h0;
                end
            end
        end
    end

    assign stallMEM        = w_access && !w_rsp && !w_timeout;
    assign loadDataWB      = r_load_data;
    assign loadValidWB     = r_load_valid;
    assign misalignedFault = !rst && (r_state == LSU_IDLE) && memReqMEM && w_legal && !w_aligned;
    assign accessError     = r_rsp_err
                          || (!rst && (r_state == LSU_IDLE) && memReqMEM && !w_legal);
endmodule

// File: tb/tb_lsu_controller.sv
module tb_lsu_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        memReqMEM, memWeMEM;
    logic [31:0] dmAddrMEM, storeDataMEM;
    logic [2:0]  loadStoreByteSelectMEM;
    logic        stallMEM, loadValidWB, misalignedFault, accessError;
    logic [31:0] loadDataWB;
    int          n_checks = 0;
    int          n_errors = 0;

    lsu_controller_if dm_if ();

    lsu_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .memReqMEM              (memReqMEM),
        .memWeMEM               (memWeMEM),
        .dmAddrMEM              (dmAddrMEM),
        .storeDataMEM           (storeDataMEM),
        .loadStoreByteSelectMEM (loadStoreByteSelectMEM),
        .stallMEM               (stallMEM),
        .loadDataWB             (loadDataWB),
        .loadValidWB            (loadValidWB),
        .misalignedFault        (misalignedFault),
        .accessError            (accessError),
        .dm                     (dm_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        memReqMEM = 0; memWeMEM = 0; dmAddrMEM = 0; storeDataMEM = 0;
        loadStoreByteSelectMEM = 3'b000;
        dm_if.dmGnt = 0; dm_if.dmRValid = 0; dm_if.dmRData = 0; dm_if.dmErr = 0;
    endtask

    // Load with grant in the request cycle and response in the next
    task automatic load_imm(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] rdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_data);
        logic [31:0] exp_addr;
        exp_addr = {addr[31:2], 2'b00};
        cyc();
        memReqMEM = 1; memWeMEM = 0; dmAddrMEM = addr; loadStoreByteSelectMEM = f3;
        dm_if.dmGnt = 1;
        #1;
        chk({tag, "_req"},   dm_if.dmReq, 1);
        chk({tag, "_addr"},  dm_if.dmAddr, exp_addr);
        chk({tag, "_be"},    {28'h0, dm_if.dmBe}, {28'h0, exp_be});
        chk({tag, "_we"},    dm_if.dmWe, 0);
        chk({tag, "_stall"}, stallMEM, 1);
        cyc();
        dm_if.dmGnt = 0; dm_if.dmRValid = 1; dm_if.dmRData = rdata;
        #1;
        chk({tag, "_req_rsp"},   dm_if.dmReq, 0);
        chk({tag, "_stall_rsp"}, stallMEM, 0);
        cyc();
        idle_inputs();
        #1;
        chk({tag, "_valid"}, loadValidWB, 1);
        chk({tag, "_data"},  loadDataWB, exp_data);
        $display("load %s addr=%h f3=%b rdata=%h -> %h", tag, addr, f3, rdata, loadDataWB);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        // ---- reset state
        cyc();
        cyc();
        memReqMEM = 1; dmAddrMEM = 32'h100; loadStoreByteSelectMEM = 3'b010; dm_if.dmGnt = 1;
        #1;
        chk("rst_req",   dm_if.dmReq, 0);
        chk("rst_we",    dm_if.dmWe, 0);
        chk("rst_be",    {28'h0, dm_if.dmBe}, 0);
        chk("rst_addr",  dm_if.dmAddr, 0);
        chk("rst_wdata", dm_if.dmWData, 0);
        chk("rst_ldata", loadDataWB, 0);
        chk("rst_lval",  loadValidWB, 0);
        chk("rst_mis",   misalignedFault, 0);
        chk("rst_aerr",  accessError, 0);
        cyc();
        idle_inputs();
        rst = 0;
        #1;
        chk("post_rst_req", dm_if.dmReq, 0);
        $display("reset released");

        // ---- loads
        load_imm("lw",  32'h100, 3'b010, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        cyc();
        #1;
        chk("lw_valid_pulse", loadValidWB, 0);
        chk("lw_hold",        loadDataWB, 32'hDEADBEEF);
        load_imm("lb",  32'h103, 3'b000, 32'h80112233, 4'b1000, 32'hFFFFFF80);
        load_imm("lbu", 32'h103, 3'b100, 32'h80112233, 4'b1000, 32'h00000080);
        load_imm("lhu", 32'h102, 3'b101, 32'h80112233, 4'b1100, 32'h00008011);
        load_imm("lh",  32'h102, 3'b001, 32'h80112233, 4'b1100, 32'hFFFF8011);
        load_imm("lb1", 32'h101, 3'b000, 32'h80112233, 4'b0010, 32'h00000022);

        // ---- SH with grant on the third request cycle; MEM data changes are ignored
        cyc();
        memReqMEM = 1; memWeMEM = 1; dmAddrMEM = 32'h206; storeDataMEM = 32'h0000ABCD;
        loadStoreByteSelectMEM = 3'b001;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) dm_if.dmGnt = 1;
            #1;
            chk("sh_req",   dm_if.dmReq, 1);
            chk("sh_be",    {28'h0, dm_if.dmBe}, 32'hC);
            chk("sh_wdata", dm_if.dmWData, 32'hABCDABCD);
            chk("sh_addr",  dm_if.dmAddr, 32'h204);
            chk("sh_we",    dm_if.dmWe, 1);
            chk("sh_stall", stallMEM, 1);
            cyc();
            storeDataMEM = 32'h12345678;
        end
        dm_if.dmGnt = 0;
        #1;
        chk("sh_wait_req",   dm_if.dmReq, 0);
        chk("sh_wait_stall", stallMEM, 1);
        cyc();
        dm_if.dmRValid = 1;
        #1;
        chk("sh_rsp_stall", stallMEM, 0);
        cyc();
        idle_inputs();
        #1;
        chk("sh_no_lval", loadValidWB, 0);
        chk("sh_ldata_hold", loadDataWB, 32'h00000022);
        $display("store SH addr=206 data=0000ABCD gnt delayed 3");

        // ---- SB, immediate grant
        cyc();
        memReqMEM = 1; memWeMEM = 1; dmAddrMEM = 32'h101; storeDataMEM = 32'h000000A5;
        loadStoreByteSelectMEM = 3'b000; dm_if.dmGnt = 1;
        #1;
        chk("sb_be",    {28'h0, dm_if.dmBe}, 32'h2);
        chk("sb_wdata", dm_if.dmWData, 32'hA5A5A5A5);
        cyc();
        dm_if.dmGnt = 0; dm_if.dmRValid = 1;
        #1;
        chk("sb_rsp_stall", stallMEM, 0);
        cyc();
        idle_inputs();
        $display("store SB addr=101 data=A5");

        // ---- misaligned LW and LH
        memReqMEM = 1; dmAddrMEM = 32'h101; loadStoreByteSelectMEM = 3'b010;
        #1;
        chk("mis_lw_fault", misalignedFault, 1);
        chk("mis_lw_req",   dm_if.dmReq, 0);
        chk("mis_lw_stall", stallMEM, 0);
        chk("mis_lw_aerr",  accessError, 0);
        cyc();
        dmAddrMEM = 32'h103; loadStoreByteSelectMEM = 3'b001;
        #1;
        chk("mis_lh_fault", misalignedFault, 1);
        chk("mis_lh_req",   dm_if.dmReq, 0);
        cyc();
        idle_inputs();
        #1;
        chk("mis_clear", misalignedFault, 0);
        $display("misaligned LW 101 / LH 103");

        // ---- illegal funct3
        memReqMEM = 1; dmAddrMEM = 32'h100; loadStoreByteSelectMEM = 3'b011;
        #1;
        chk("ill_aerr",  accessError, 1);
        chk("ill_req",   dm_if.dmReq, 0);
        chk("ill_stall", stallMEM, 0);
        chk("ill_mis",   misalignedFault, 0);
        cyc();
        idle_inputs();
        #1;
        chk("ill_clear", accessError, 0);
        $display("illegal funct3 011");

        // ---- error response on LW
        memReqMEM = 1; dmAddrMEM = 32'h300; loadStoreByteSelectMEM = 3'b010; dm_if.dmGnt = 1;
        #1;
        chk("err_req", dm_if.dmReq, 1);
        cyc();
        dm_if.dmGnt = 0; dm_if.dmRValid = 1; dm_if.dmErr = 1; dm_if.dmRData = 32'hFFFFFFFF;
        #1;
        chk("err_aerr_early", accessError, 0);
        cyc();
        idle_inputs();
        #1;
        chk("err_aerr",  accessError, 1);
        chk("err_lval",  loadValidWB, 1);
        chk("err_ldata", loadDataWB, 0);
        cyc();
        #1;
        chk("err_aerr_clear", accessError, 0);
        $display("error response LW 300");

        // ---- stray grant/response while idle
        dm_if.dmGnt = 1; dm_if.dmRValid = 1; dm_if.dmRData = 32'h12345678;
        #1;
        chk("stray_req", dm_if.dmReq, 0);
        cyc();
        idle_inputs();
        #1;
        chk("stray_lval",  loadValidWB, 0);
        chk("stray_ldata", loadDataWB, 0);
        $display("stray gnt/rvalid in idle");

        // ---- reset while waiting for the response
        memReqMEM = 1; dmAddrMEM = 32'h400; loadStoreByteSelectMEM = 3'b010; dm_if.dmGnt = 1;
        #1;
        chk("rma_req", dm_if.dmReq, 1);
        cyc();
        dm_if.dmGnt = 0; rst = 1;
        #1;
        chk("rma_req_rst", dm_if.dmReq, 0);
        cyc();
        rst = 0; memReqMEM = 0; dm_if.dmRValid = 1; dm_if.dmRData = 32'h00000055;
        #1;
        chk("rma_stall", stallMEM, 0);
        cyc();
        idle_inputs();
        #1;
        chk("rma_lval", loadValidWB, 0);
        chk("rma_ldata", loadDataWB, 0);
        $display("reset mid-access, late rvalid dropped");
        load_imm("lw_after_rst", 32'h104, 3'b010, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

`ifdef LSU_TIMEOUT_EN
        // ---- timeout: no grant ever arrives
        cyc();
        memReqMEM = 1; dmAddrMEM = 32'h500; loadStoreByteSelectMEM = 3'b010;
        #1;
        chk("to_req0", dm_if.dmReq, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk("to_req_wait",   dm_if.dmReq, 1);
            chk("to_stall_wait", stallMEM, 1);
        end
        cyc();
        #1;
        chk("to_drop",  dm_if.dmReq, 0);
        chk("to_stall", stallMEM, 0);
        cyc();
        idle_inputs();
        #1;
        chk("to_aerr",  accessError, 1);
        chk("to_ldata", loadDataWB, 0);
        $display("timeout LW 500");
`endif

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
